fib_bcd_ctl_param: RTL and testbench

//  Parametrised BCD-in/BCD-out sequence generator. Successor to the fixed 2-in/4-out Fibonacci controller.

---
 rtl/fib_pkg.sv | 25 ++
 rtl/bin2bcd_dd.sv | 62 ++++++
 rtl/fib_bcd_ctl_param.sv | 189 ++++++++++++++++++
 tb/tb_fib_bcd_ctl_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the BCD Fibonacci/Lucas term generator.
// pow10 sizes the result limit and the width of n from the digit counts.
package fib_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CONV  = 3'd1,
      FIB   = 3'd2,
      B2BCD = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic {
      MODE_FIB   = 1'b0,
      MODE_LUCAS = 1'b1
   } mode_e;

   function automatic longint pow10(input int e);
      longint r;
      r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble: one add-3/shift step per cycle, BIN_W steps.
// o_done is high during the last step, so o_bcd is final on the following cycle.
module bin2bcd_dd #(
   parameter int BIN_W      = 14,
   parameter int OUT_DIGITS = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic [BIN_W-1:0]        i_bin,
   output logic [4*OUT_DIGITS-1:0] o_bcd,
   output logic                    o_done
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * OUT_DIGITS;

   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < OUT_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (i_start) begin
         bin_d  = i_bin;
         bcd_d  = '0;
         cnt_d  = CNT_W'(BIN_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
         bin_d = {bin_q[BIN_W-2:0], 1'b0};
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign o_bcd  = bcd_q;
   assign o_done = busy_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fib_bcd_ctl_param.sv
// BCD n in, BCD Fibonacci/Lucas term out, with digit validation and overflow flag.
// Handshake: i_start is taken only on an edge where o_ready=1; o_done pulses once per accepted start.
module fib_bcd_ctl_param
   import fib_pkg::*;
#(
   parameter int IN_DIGITS  = 2,
   parameter int OUT_DIGITS = 4,
   parameter int BIN_W      = 14
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_mode,
   input  logic [4*IN_DIGITS-1:0]  i_gen_amt_bcd,
   output logic [4*OUT_DIGITS-1:0] o_final_bcd,
   output logic                    o_ready,
   output logic                    o_done,
   output logic                    o_overflow,
   output logic                    o_err,
   output logic [2:0]              o_dbg_state
);

   localparam longint MAX   = pow10(OUT_DIGITS) - 1;
   localparam longint N_MAX = pow10(IN_DIGITS) - 1;
   localparam int     N_W   = $clog2(N_MAX + 1);
   localparam int     DIG_W = $clog2(IN_DIGITS + 1);
   localparam int     AMT_W = 4 * IN_DIGITS;
   localparam int     BCD_W = 4 * OUT_DIGITS;
   localparam logic [BIN_W:0]   MAX_V     = (BIN_W+1)'(MAX);
   localparam logic [BCD_W-1:0] ALL_NINES = {OUT_DIGITS{4'h9}};

   generate
      if ((longint'(1) << BIN_W) <= MAX) begin : g_bad_bin_w
         $error("fib_bcd_ctl_param: BIN_W too narrow for OUT_DIGITS");
      end
   endgenerate

   state_t             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [AMT_W-1:0]   amt_q, amt_d;
   logic [DIG_W-1:0]   dig_q, dig_d;
   logic [N_W-1:0]     n_q, n_d, cnt_q, cnt_d;
   logic [BIN_W:0]     t0_q, t0_d, t1_q, t1_d;
   logic               err_acc_q, err_acc_d, ovf_acc_q, ovf_acc_d;
   logic [BCD_W-1:0]   final_q, final_d;
   logic               done_q, done_d, ovf_q, ovf_d, err_q, err_d;
   logic [3:0]         digit;
   logic [N_W+3:0]     n_acc;
   logic               digit_bad, last_dig, fib_hit, fib_ovf;
   logic               b2b_start, b2b_done;
   logic [BCD_W-1:0]   b2b_bcd;

   assign digit     = amt_q[AMT_W-1 -: 4];
   assign digit_bad = digit > 4'd9;
   assign last_dig  = dig_q == DIG_W'(IN_DIGITS - 1);
   assign fib_hit   = cnt_q == n_q;
   assign fib_ovf   = t1_q > MAX_V;
   assign n_acc     = ({4'd0, n_q} << 3) + ({4'd0, n_q} << 1) + (N_W+4)'(digit);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         mode_q    <= MODE_FIB;
         amt_q     <= '0;
         dig_q     <= '0;
         n_q       <= '0;
         cnt_q     <= '0;
         t0_q      <= '0;
         t1_q      <= '0;
         err_acc_q <= 1'b0;
         ovf_acc_q <= 1'b0;
         final_q   <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         amt_q     <= amt_d;
         dig_q     <= dig_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         t0_q      <= t0_d;
         t1_q      <= t1_d;
         err_acc_q <= err_acc_d;
         ovf_acc_q <= ovf_acc_d;
         final_q   <= final_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = CONV;
         CONV:    if (last_dig) state_d = (err_acc_q || digit_bad) ? DONE : FIB;
         FIB: begin
            if (fib_hit)      state_d = B2BCD;
            else if (fib_ovf) state_d = DONE;
         end
         B2BCD:   if (b2b_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mode_d    = mode_q;
      amt_d     = amt_q;
      dig_d     = dig_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      t0_d      = t0_q;
      t1_d      = t1_q;
      err_acc_d = err_acc_q;
      ovf_acc_d = ovf_acc_q;
      final_d   = final_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               amt_d     = i_gen_amt_bcd;
               mode_d    = mode_e'(i_mode);
               dig_d     = '0;
               n_d       = '0;
               err_acc_d = 1'b0;
               ovf_acc_d = 1'b0;
            end
         end
         CONV: begin
            n_d   = n_acc[N_W-1:0];
            amt_d = amt_q << 4;
            dig_d = dig_q + 1'b1;
            if (digit_bad) err_acc_d = 1'b1;
            if (last_dig) begin
               cnt_d = '0;
               t0_d  = (mode_q == MODE_LUCAS) ? (BIN_W+1)'(2) : '0;
               t1_d  = (BIN_W+1)'(1);
            end
         end
         FIB: begin
            // Terms never decrease, so the first t1 above MAX proves term n overflows.
            if (!fib_hit) begin
               if (fib_ovf) begin
                  ovf_acc_d = 1'b1;
               end else begin
                  t0_d  = t1_q;
                  t1_d  = t0_q + t1_q;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            err_d   = err_acc_q;
            ovf_d   = ovf_acc_q && !err_acc_q;
            final_d = err_acc_q ? '0 : (ovf_acc_q ? ALL_NINES : b2b_bcd);
         end
         default: ;
      endcase
   end

   always_comb begin
      b2b_start   = (state_q == FIB) && fib_hit;
      o_ready     = state_q == IDLE;
      o_done      = done_q;
      o_final_bcd = final_q;
      o_overflow  = ovf_q;
      o_err       = err_q;
      o_dbg_state = state_q;
   end

   bin2bcd_dd #(
      .BIN_W      (BIN_W),
      .OUT_DIGITS (OUT_DIGITS)
   ) u_b2b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (b2b_start),
      .i_bin   (t0_q[BIN_W-1:0]),
      .o_bcd   (b2b_bcd),
      .o_done  (b2b_done)
   );

endmodule

// File: tb/tb_fib_bcd_ctl_param.sv
// Bench for fib_bcd_ctl_param: a 4-digit and a 6-digit instance share the same inputs.
// Directed vectors carry hand-computed results; the full n sweep uses an arithmetic reference.
module tb_fib_bcd_ctl_param;
   import fib_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_mode = 1'b0;
   logic [7:0]  i_gen = 8'h00;

   logic [15:0] a_bcd;
   logic        a_ready, a_done, a_ovf, a_err;
   logic [2:0]  a_state;
   logic [23:0] b_bcd;
   logic        b_ready, b_done, b_ovf, b_err;
   logic [2:0]  b_state;

   int errors = 0;
   int checks = 0;

   // results captured by run()
   logic [15:0] ra_bcd;
   logic [23:0] rb_bcd;
   logic        ra_ovf, ra_err, rb_ovf, rb_err;
   int          ra_lat, rb_lat, a_pulses, b_pulses;

   typedef struct {
      logic [7:0]  nb;
      bit          mode;
      logic [15:0] bcd;
      bit          ovf;
      bit          err;
      int          lat;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   fib_bcd_ctl_param #(.IN_DIGITS(2), .OUT_DIGITS(4), .BIN_W(14)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
      .i_gen_amt_bcd(i_gen), .o_final_bcd(a_bcd), .o_ready(a_ready),
      .o_done(a_done), .o_overflow(a_ovf), .o_err(a_err), .o_dbg_state(a_state)
   );

   fib_bcd_ctl_param #(.IN_DIGITS(2), .OUT_DIGITS(6), .BIN_W(20)) dut6 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
      .i_gen_amt_bcd(i_gen), .o_final_bcd(b_bcd), .o_ready(b_ready),
      .o_done(b_done), .o_overflow(b_ovf), .o_err(b_err), .o_dbg_state(b_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint to_bcd(input longint v);
      longint r, x;
      r = 0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r = r | ((x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model(input logic [7:0] nb, input bit mode, input longint maxv, input int binw,
                        output longint bcd, output bit ovf, output bit err, output int lat);
      longint t0, t1, tn;
      int n, cnt;
      ovf = 0;
      err = 0;
      if (nb[7:4] > 4'd9 || nb[3:0] > 4'd9) begin
         err = 1;
         bcd = 0;
         lat = 3;
         return;
      end
      n   = int'(nb[7:4]) * 10 + int'(nb[3:0]);
      t0  = mode ? 2 : 0;
      t1  = 1;
      cnt = 0;
      while (1) begin
         if (cnt == n) begin
            bcd = to_bcd(t0);
            lat = 2 + (cnt + 1) + binw + 1;
            return;
         end else if (t1 > maxv) begin
            ovf = 1;
            bcd = to_bcd(maxv);
            lat = 2 + (cnt + 1) + 1;
            return;
         end
         tn  = t0 + t1;
         t0  = t1;
         t1  = tn;
         cnt = cnt + 1;
      end
   endtask

   // Start one operation on both instances; a nonzero poke_at pulses i_start while busy.
   task automatic run(input logic [7:0] nb, input bit mode, input int poke_at);
      int cyc;
      bit got_a, got_b;
      @(negedge clk);
      i_gen   = nb;
      i_mode  = mode;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start  = 1'b0;
      got_a    = 0;
      got_b    = 0;
      a_pulses = 0;
      b_pulses = 0;
      cyc      = 0;
      while (!(got_a && got_b) && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) check("busy_not_ready", a_ready, 1'b0);
         if (poke_at != 0 && cyc == poke_at) begin
            i_start = 1'b1;
            i_gen   = 8'h05;
         end else if (poke_at != 0 && cyc == poke_at + 1) begin
            i_start = 1'b0;
         end
         if (a_done) begin
            a_pulses++;
            if (!got_a) begin
               got_a = 1; ra_lat = cyc; ra_bcd = a_bcd; ra_ovf = a_ovf; ra_err = a_err;
            end
         end
         if (b_done) begin
            b_pulses++;
            if (!got_b) begin
               got_b = 1; rb_lat = cyc; rb_bcd = b_bcd; rb_ovf = b_ovf; rb_err = b_err;
            end
         end
      end
      check("done_seen", {got_a, got_b}, 2'b11);
      @(posedge clk);
      #1;
      if (a_done) a_pulses++;
      if (b_done) b_pulses++;
      check("a_single_pulse", a_pulses, 1);
      check("b_single_pulse", b_pulses, 1);
      check("ready_after", {a_ready, b_ready}, 2'b11);
   endtask

   initial begin
      longint m_bcd;
      bit     m_ovf, m_err;
      int     m_lat, nd;

      vecs = '{
         '{8'h10, 1'b0, 16'h0055, 1'b0, 1'b0, 28},
         '{8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 18},
         '{8'h01, 1'b0, 16'h0001, 1'b0, 1'b0, 19},
         '{8'h00, 1'b1, 16'h0002, 1'b0, 1'b0, 18},
         '{8'h01, 1'b1, 16'h0001, 1'b0, 1'b0, 19},
         '{8'h20, 1'b0, 16'h6765, 1'b0, 1'b0, 38},
         '{8'h21, 1'b0, 16'h9999, 1'b1, 1'b0, 24},
         '{8'h19, 1'b1, 16'h9349, 1'b0, 1'b0, 37},
         '{8'h20, 1'b1, 16'h9999, 1'b1, 1'b0, 23},
         '{8'h1A, 1'b0, 16'h0000, 1'b0, 1'b1, 3},
         '{8'h10, 1'b0, 16'h0055, 1'b0, 1'b0, 28},
         '{8'h99, 1'b0, 16'h9999, 1'b1, 1'b0, 24},
         '{8'hA0, 1'b1, 16'h0000, 1'b0, 1'b1, 3}
      };

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", a_ready, 1'b1);
      check("rst_done", a_done, 1'b0);
      check("rst_flags", {a_ovf, a_err}, 2'b00);
      check("rst_bcd", a_bcd, 16'h0000);
      check("rst_bcd6", b_bcd, 24'h000000);
      check("rst_state", a_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // directed vectors
      for (int i = 0; i < 13; i++) begin
         run(vecs[i].nb, vecs[i].mode, 0);
         check($sformatf("dir%0d_bcd", i), ra_bcd, vecs[i].bcd);
         check($sformatf("dir%0d_ovf", i), ra_ovf, vecs[i].ovf);
         check($sformatf("dir%0d_err", i), ra_err, vecs[i].err);
         check($sformatf("dir%0d_lat", i), ra_lat, vecs[i].lat);
      end

      // wide instance: F(30) fits in six digits, overflows four
      run(8'h30, 1'b0, 0);
      check("f30_bcd6", rb_bcd, 24'h832040);
      check("f30_ovf6", rb_ovf, 1'b0);
      check("f30_lat6", rb_lat, 54);
      check("f30_ovf4", ra_ovf, 1'b1);
      check("f30_lat4", ra_lat, 24);

      // start pulsed while busy must not disturb the run
      run(8'h10, 1'b0, 5);
      check("poke_bcd", ra_bcd, 16'h0055);
      check("poke_lat", ra_lat, 28);

      // reset in the middle of FIB
      run(8'h20, 1'b0, 0);
      @(negedge clk);
      i_gen   = 8'h50;
      i_mode  = 1'b0;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_state_fib", a_state, FIB);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_ready", a_ready, 1'b1);
      check("mid_rst_done", a_done, 1'b0);
      check("mid_rst_bcd", a_bcd, 16'h0000);
      check("mid_rst_flags", {a_ovf, a_err}, 2'b00);
      check("mid_rst_bcd6", b_bcd, 24'h000000);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         if (a_done || b_done) nd++;
      end
      check("mid_rst_no_done", nd, 0);

      // sweep both modes over every n against the reference
      for (int m = 0; m < 2; m++) begin
         for (int n = 0; n < 100; n++) begin
            logic [7:0] nb;
            nb = {4'(n / 10), 4'(n % 10)};
            run(nb, m[0], 0);
            model(nb, m[0], 64'd9999, 14, m_bcd, m_ovf, m_err, m_lat);
            check($sformatf("sw4_m%0d_n%0d_bcd", m, n), ra_bcd, m_bcd);
            check($sformatf("sw4_m%0d_n%0d_ovf", m, n), {ra_ovf, ra_err}, {m_ovf, m_err});
            check($sformatf("sw4_m%0d_n%0d_lat", m, n), ra_lat, m_lat);
            model(nb, m[0], 64'd999999, 20, m_bcd, m_ovf, m_err, m_lat);
            check($sformatf("sw6_m%0d_n%0d_bcd", m, n), rb_bcd, m_bcd);
            check($sformatf("sw6_m%0d_n%0d_ovf", m, n), {rb_ovf, rb_err}, {m_ovf, m_err});
            check($sformatf("sw6_m%0d_n%0d_lat", m, n), rb_lat, m_lat);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
